// File: rtl/rom_program_loader_if.sv
// Loader bus: command/status, incoming byte stream and instruction-memory write port.
// master drives the command and byte stream; slave is the loader.
interface rom_program_loader_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   Start_i;
    logic [COUNT_WIDTH-1:0] Word_Count_i;
    logic [7:0]             Byte_i;
    logic                   Byte_Valid_i;
    logic                   Byte_Ready_o;
    logic                   Wr_En_o;
    logic [DATA_WIDTH-1:0]  Wr_Address_o;
    logic [DATA_WIDTH-1:0]  Wr_Data_o;
    logic                   Busy_o;
    logic                   Done_o;
    logic                   Error_o;

    modport master (
        output Start_i, Word_Count_i, Byte_i, Byte_Valid_i,
        input  Byte_Ready_o, Wr_En_o, Wr_Address_o, Wr_Data_o, Busy_o, Done_o, Error_o
    );

    modport slave (
        input  Start_i, Word_Count_i, Byte_i, Byte_Valid_i,
        output Byte_Ready_o, Wr_En_o, Wr_Address_o, Wr_Data_o, Busy_o, Done_o, Error_o
    );
endinterface

// File: rtl/rom_program_loader.sv
// Packs a byte stream big-endian into 32-bit instruction-memory writes from BASE_ADDRESS up.
// Write strobe the cycle after the 4th byte; ready only while collecting, so Byte_Valid_i may stall freely.
module rom_program_loader #(
    parameter int              DATA_WIDTH   = 32,
    parameter int              MEMORY_DEPTH = 64,
    parameter logic [31:0]     BASE_ADDRESS = 32'h0040_0000,
    parameter int              COUNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    rom_program_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(BASE_ADDRESS);

    state_t                 state_q, state_d;
    logic [1:0]             byte_cnt_q;
    logic [DATA_WIDTH-1:0]  word_q;
    logic [DATA_WIDTH-1:0]  addr_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] words_done_q;
    logic [DATA_WIDTH-1:0]  wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   error_q;

    logic                   count_zero;
    logic                   count_too_big;
    logic                   start_accept;
    logic                   byte_xfer;
    logic                   last_word;
    logic [DATA_WIDTH-1:0]  word_next;

    assign count_zero    = (bus.Word_Count_i == '0);
    assign count_too_big = ({1'b0, bus.Word_Count_i} > (COUNT_WIDTH+1)'(MEMORY_DEPTH));
    assign word_next     = {word_q[DATA_WIDTH-9:0], bus.Byte_i};
    assign last_word     = ((words_done_q + COUNT_WIDTH'(1)) == count_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        byte_xfer    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start_i) begin
                    if (count_zero || count_too_big) begin
                        state_d = S_DONE;
                    end else begin
                        start_accept = 1'b1;
                        state_d      = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                byte_xfer = bus.Byte_Valid_i;
                if (bus.Byte_Valid_i && (byte_cnt_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = last_word ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt_q   <= '0;
            word_q       <= '0;
            addr_q       <= BASE;
            count_q      <= '0;
            words_done_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            error_q      <= 1'b0;
        end else begin
            // Error reflects only the most recent Start_i taken in IDLE.
            if ((state_q == S_IDLE) && bus.Start_i) begin
                error_q <= count_too_big;
            end
            if (start_accept) begin
                count_q      <= bus.Word_Count_i;
                addr_q       <= BASE;
                byte_cnt_q   <= '0;
                words_done_q <= '0;
            end
            if (byte_xfer) begin
                word_q     <= word_next;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                // Capture the write beat here so address/data hold after the strobe drops.
                if (byte_cnt_q == 2'd3) begin
                    wr_addr_q <= addr_q;
                    wr_data_q <= word_next;
                end
            end
            if (state_q == S_WRITE) begin
                words_done_q <= words_done_q + COUNT_WIDTH'(1);
                addr_q       <= addr_q + DATA_WIDTH'(4);
                byte_cnt_q   <= '0;
            end
        end
    end

    assign bus.Byte_Ready_o = (state_q == S_COLLECT);
    assign bus.Wr_En_o      = (state_q == S_WRITE);
    assign bus.Wr_Address_o = wr_addr_q;
    assign bus.Wr_Data_o    = wr_data_q;
    assign bus.Busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign bus.Done_o       = (state_q == S_DONE);
    assign bus.Error_o      = error_q;
endmodule

// File: tb/tb_rom_program_loader.sv
// Scoreboarded bench: expected writes/done events are queued at stimulus time and
// popped by an independent monitor that samples on the falling edge.
module tb_rom_program_loader;
    localparam int          DW    = 32;
    localparam int          CW    = 16;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          BUDGET = 200;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rom_program_loader_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    rom_program_loader #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(DEPTH),
        .BASE_ADDRESS(BASE),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic err; logic after_write; } done_t;

    wr_t        wq[$];
    done_t      dq[$];
    logic [7:0] byte_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic       prev_wr  = 1'b0;
    wr_t        mon_w;
    done_t      mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.Wr_En_o) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h at %0t",
                             bus.Wr_Address_o, bus.Wr_Data_o, $time);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", bus.Wr_Address_o, mon_w.addr);
                    chk("wr_data", bus.Wr_Data_o, mon_w.data);
                end
            end
            if (bus.Busy_o)
                chk("ready_in_collect_only", {31'd0, bus.Byte_Ready_o}, {31'd0, !bus.Wr_En_o});
            if (bus.Done_o) begin
                if (dq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
                end else begin
                    mon_d = dq.pop_front();
                    chk("done_error", {31'd0, bus.Error_o}, {31'd0, mon_d.err});
                    chk("done_after_write", {31'd0, prev_wr}, {31'd0, mon_d.after_write});
                    chk("done_busy", {31'd0, bus.Busy_o}, 32'd0);
                    chk("done_pending_writes", wq.size(), 32'd0);
                end
            end
        end
        prev_wr = bus.Wr_En_o;
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.Byte_Ready_o}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, bus.Wr_En_o}, 32'd0);
        chk({tag, "_wr_addr"}, bus.Wr_Address_o, 32'd0);
        chk({tag, "_wr_data"}, bus.Wr_Data_o, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.Busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.Done_o}, 32'd0);
        chk({tag, "_error"}, {31'd0, bus.Error_o}, 32'd0);
    endtask

    // Reference model: word i = bytes 4i..4i+3 big-endian at BASE + 4i.
    task automatic expect_load(input int cnt);
        wr_t w;
        done_t d;
        if (cnt == 0) begin
            d.err = 1'b0; d.after_write = 1'b0;
        end else if (cnt > DEPTH) begin
            d.err = 1'b1; d.after_write = 1'b0;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                w.addr = BASE + 32'(4 * i);
                w.data = {byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]};
                wq.push_back(w);
            end
            d.err = 1'b0; d.after_write = 1'b1;
        end
        dq.push_back(d);
    endtask

    task automatic pulse_start(input int cnt);
        bus.Word_Count_i = CW'(cnt);
        bus.Start_i      = 1'b1;
        @(negedge clk);
        bus.Start_i      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.Byte_Valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        bus.Byte_i       = b;
        bus.Byte_Valid_i = 1'b1;
        n = 0;
        while (!bus.Byte_Ready_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++; failures++;
            $display("FAIL byte_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(negedge clk);
        bus.Byte_Valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL done_timeout: pending %0d expected 0 at %0t", dq.size(), $time);
            dq.delete();
            wq.delete();
        end
        @(negedge clk);
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic run_load(input int cnt, input int gmin, input int gmax, input int restart_word);
        expect_load(cnt);
        pulse_start(cnt);
        if (cnt >= 1 && cnt <= DEPTH) begin
            for (int w = 0; w < cnt; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w == restart_word && b == 0) begin
                        bus.Start_i      = 1'b1;
                        bus.Word_Count_i = CW'(3);
                    end
                    send_byte(byte_q.pop_front(), int'($urandom_range(gmax, gmin)));
                    bus.Start_i = 1'b0;
                end
            end
        end
        wait_done();
    endtask

    initial begin
        bus.Start_i      = 1'b0;
        bus.Word_Count_i = '0;
        bus.Byte_i       = '0;
        bus.Byte_Valid_i = 1'b0;
        reset            = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.Byte_Ready_o}, 32'd0);
        chk("idle_busy", {31'd0, bus.Busy_o}, 32'd0);

        byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(2, 0, 0, -1);

        byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(2, 3, 3, -1);

        expect_load(0);
        pulse_start(0);
        chk("zero_count_done_next", {31'd0, bus.Done_o}, 32'd1);
        chk("zero_count_error", {31'd0, bus.Error_o}, 32'd0);
        wait_done();

        expect_load(DEPTH + 1);
        pulse_start(DEPTH + 1);
        chk("over_depth_done_next", {31'd0, bus.Done_o}, 32'd1);
        chk("over_depth_error", {31'd0, bus.Error_o}, 32'd1);
        wait_done();
        chk("error_sticky_idle", {31'd0, bus.Error_o}, 32'd1);

        pulse_start(1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("midload_reset");
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", {31'd0, bus.Busy_o}, 32'd0);
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, -1);

        fill_random(4 * DEPTH);
        run_load(DEPTH, 0, 1, 20);
        chk("full_load_last_addr", bus.Wr_Address_o, BASE + 32'h0000_00FC);

        for (int it = 0; it < 12; it++) begin
            int kind;
            int cnt;
            kind = int'($urandom_range(9, 0));
            if (kind == 0)      cnt = 0;
            else if (kind == 1) cnt = int'($urandom_range(65535, DEPTH + 1));
            else                cnt = int'($urandom_range(8, 1));
            fill_random(4 * cnt * ((cnt <= DEPTH) ? 1 : 0));
            run_load(cnt, 0, 2, -1);
        end

        repeat (10) @(negedge clk);
        chk("final_writes_drained", wq.size(), 32'd0);
        chk("final_dones_drained", dq.size(), 32'd0);
        chk("final_idle_busy", {31'd0, bus.Busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
